// File: rtl/npu_bus_pkg.sv
// Shared opcodes and register-map constants for the NPU slave-port bus master.
package npu_bus_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_POLL  = 2'd2
    } op_e;

    localparam logic [2:0] SEL_IMG   = 3'd1;
    localparam logic [2:0] SEL_W     = 3'd2;
    localparam logic [2:0] SEL_FCN   = 3'd3;
    localparam logic [2:0] SEL_CTRL  = 3'd4;
    localparam logic [2:0] SEL_DONE  = 3'd5;
    localparam logic [2:0] SEL_RES   = 3'd6;
    localparam logic [2:0] SEL_VALID = 3'd7;

    localparam int TRIG     = 0;
    localparam int NEXT     = 1;
    localparam int PE_CLR   = 2;
    localparam int IMG_CLR  = 3;
    localparam int W_CLR    = 4;
    localparam int PACK_CLR = 5;

endpackage

// File: rtl/npu_bus_master.sv
// Command-driven initiator for the NPU slave port: turns WRITE/READ/POLL commands
// into timed single-cycle bus accesses and returns read/poll results.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR      | write access on the bus (ena=wea=1)
// GAP     | idle bus cycle after a control-bank write so the slave clears its pulses
// RD      | read access on the bus (ena=1, wea=0)
// RD_WAIT | bus idle, registered douta captured at the end of the cycle
// RSP     | rsp_valid high until rsp_ready
module npu_bus_master
    import npu_bus_pkg::*;
#(
    parameter int POLL_MAX = 1024
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        ena,
    output logic        wea,
    output logic [15:0] addra,
    output logic [31:0] dina,
    input  logic [31:0] douta
);

    localparam int CW = $clog2(POLL_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(POLL_MAX);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        GAP,
        RD,
        RD_WAIT,
        RSP
    } state_e;

    state_e          state;
    op_e             op_q;
    logic [31:0]     mask_q;
    logic [CW-1:0]   poll_cnt;

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            op_q        <= OP_WRITE;
            mask_q      <= '0;
            poll_cnt    <= '0;
            ena         <= 1'b0;
            wea         <= 1'b0;
            addra       <= '0;
            dina        <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= op_e'(cmd_op);
                        mask_q   <= cmd_data;
                        poll_cnt <= '0;
                        case (cmd_op)
                            2'd0: begin
                                ena   <= 1'b1;
                                wea   <= 1'b1;
                                addra <= cmd_addr;
                                dina  <= cmd_data;
                                state <= WR;
                            end
                            2'd1, 2'd2: begin
                                ena         <= 1'b1;
                                wea         <= 1'b0;
                                addra       <= cmd_addr;
                                rsp_timeout <= 1'b0;
                                state       <= RD;
                            end
                            default: ;
                        endcase
                    end
                end
                WR: begin
                    ena   <= 1'b0;
                    wea   <= 1'b0;
                    state <= (addra[14:12] == SEL_CTRL) ? GAP : IDLE;
                end
                GAP: begin
                    state <= IDLE;
                end
                RD: begin
                    // poll_cnt counts reads issued, so it reaches POLL_MAX on the last one
                    ena <= 1'b0;
                    if (poll_cnt != CNT_MAX) begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    rsp_data <= douta;
                    if (op_q != OP_POLL) begin
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b0;
                        state       <= RSP;
                    end else if ((douta & mask_q) != '0) begin
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b0;
                        state       <= RSP;
                    end else if (poll_cnt == CNT_MAX) begin
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= RSP;
                    end else begin
                        ena   <= 1'b1;
                        wea   <= 1'b0;
                        state <= RD;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/npu_bus_master.md
# npu_bus_master

Command-driven initiator for the NPU's memory-mapped slave port (ena/wea/addra/dina/douta). It accepts write, read and poll commands from the control sequencer over a valid/ready handshake and turns each into correctly timed bus accesses. It enforces the slave's control-register pulse rule and returns read or poll results over a response handshake. It sits between the sequencer or CPU-side FIFO and the npu instance.

## Interface
- POLL_MAX, 1024: maximum number of reads a POLL command issues before it reports a timeout.
- clk  in  1  system clock; every register is on its rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_op  in  2  opcode: WRITE=0, READ=1, POLL=2; 3 is reserved.
- cmd_addr  in  16  slave address; bits [14:12] select the register bank.
- cmd_data  in  32  write data (WRITE) or match mask (POLL).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_data  out  32  captured douta.
- rsp_timeout  out  1  the POLL ended without a match.
- ena, wea  out  1  slave enable and write enable.
- addra  out  16  slave address.
- dina  out  32  slave write data.
- douta  in  32  slave read data, registered by the slave.

## Operation
- All bus outputs are registered. Reset values: ena=0, wea=0, addra=0, dina=0, rsp_valid=0, rsp_data=0, rsp_timeout=0.
- cmd_ready = (state==IDLE). It is therefore 1 while in reset.
- States: IDLE, WR, GAP, RD, RD_WAIT, RSP.
- IDLE: accepting a command latches cmd_op, cmd_addr and cmd_data.
  - WRITE goes to WR.
  - READ and POLL go to RD, with the poll counter set to 0.
  - Reserved op 3 is accepted and dropped. State stays IDLE and nothing is driven on the bus.
- WR: drives ena=1, wea=1, addra and dina for exactly one cycle.
  - If addra[14:12]==3'b100 (control bank), go to GAP.
  - Otherwise go to IDLE.
- GAP: drives ena=0 for one cycle, then goes to IDLE. The slave clears its control pulses only on a cycle with no access. Two control writes are therefore always separated by at least one idle cycle.
- RD: drives ena=1, wea=0 and addra for one cycle, then goes to RD_WAIT.
- RD_WAIT: ena=0. At the end of the cycle, douta is captured into rsp_data.
  - READ goes to RSP.
  - POLL, if (douta & mask)!=0: go to RSP with rsp_timeout=0.
  - POLL, else if the poll count has reached POLL_MAX: go to RSP with rsp_timeout=1. rsp_data holds the last value read.
  - POLL, otherwise: increment the poll count and go back to RD.
- RSP: rsp_valid=1. rsp_data and rsp_timeout stay stable until rsp_ready. On the handshake cycle, rsp_valid drops and the state goes to IDLE.
- WRITE commands produce no response.
- POLL counter width: $clog2(POLL_MAX+1). It never wraps; it saturates at POLL_MAX.
- Mask 0 never matches. A POLL with mask 0 always times out after POLL_MAX reads.
- Reset asserted mid-command aborts immediately:
  - bus outputs go to 0 on the same edge as the reset;
  - any pending response is lost;
  - the state returns to IDLE.

## Timing
- Command accepted in cycle T. The bus access is visible in T+1.
- WRITE: data bank next command acceptable in T+2; control bank in T+3.
- READ:
  - slave samples the read at the end of T+1;
  - douta is valid in T+2 and captured at the end of T+2;
  - rsp_valid=1 from T+3.
- POLL: each read iteration takes 2 cycles (RD, RD_WAIT). A match on read k (k=1..POLL_MAX) gives rsp_valid at T+1+2k.
- Back-to-back minimum spacing is 2 cycles per write. Bus ena is never high in two consecutive cycles.
- rsp_ready held high: RSP lasts 1 cycle, and cmd_ready returns in the following cycle.

## Structure
- Shared package npu_bus_pkg:
  - op_e enum (OP_WRITE, OP_READ, OP_POLL);
  - bank constants SEL_IMG=3'd1, SEL_W=3'd2, SEL_FCN=3'd3, SEL_CTRL=3'd4, SEL_DONE=3'd5, SEL_RES=3'd6, SEL_VALID=3'd7;
  - control bit positions TRIG=0, NEXT=1, PE_CLR=2, IMG_CLR=3, W_CLR=4, PACK_CLR=5.
- The state enum is local to the block.
- No sub-module. The FSM, the poll counter and the capture register live in one module.

## Test plan
- WRITE addr 0x1000, data 0x00030201 -> ena=wea=1 for exactly one cycle with addra=0x1000 and dina=0x00030201; cmd_ready returns after 2 cycles.
- Two WRITEs to 0x4000 (data 0x1, then 0x4) -> one cycle with ena=0 between the accesses; the slave model records two distinct pulses.
- READ 0x6000 with slave douta=0x00000123 -> rsp_valid at T+3 with rsp_data=0x123 and rsp_timeout=0; the response holds while rsp_ready is held low for 5 cycles.
- POLL 0x5000, mask 0x1, done asserted on the 4th read -> exactly 4 read accesses, rsp_data=1, rsp_timeout=0, rsp_valid at T+9.
- POLL with POLL_MAX=8 and douta always 0 -> exactly 8 reads, then rsp_timeout=1 and rsp_data=0.
- rst_ni pulsed low during RD_WAIT of a POLL -> ena=0 at once, rsp_valid=0, cmd_ready=1; the next READ completes normally.
